dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//  Data-memory responder for the M-stage data port. Receives m_data_addr, m_data_byteen,
//  m_data_wdata and m_inst_addr, and returns the word-aligned m_data_rdata.
//  Performs byte-enabled writes into a word array and zero-fills that array after reset.
//  Emits a one-cycle registered write-trace record for the grading harness.
// PARAMETERS
//  DEPTH_WORDS  3072          number of 32-bit words stored
//  BASE_ADDR    32'h0000_0000 byte address of word 0
//  IDX_W        12            word-index width, ceil(log2(DEPTH_WORDS))
// PORTS
//  clk            in   1   single clock; all state changes on posedge
//  reset          in   1   synchronous, active-low reset
//  m_data_addr    in   32  byte address from the requester; bits [1:0] ignored for indexing
//  m_data_wdata   in   32  lane-aligned write data (already shifted by the requester)
//  m_data_byteen  in   4   lane enables; bit i covers bits [8i+7:8i]; 4'b0000 = no write
//  m_inst_addr    in   32  PC of the instruction in M; used only for the trace
//  m_data_rdata   out  32  full word at the addressed index (combinational)
//  dm_ready       out  1   1 = clear finished, accesses honoured
//  wr_valid       out  1   trace strobe, one cycle per committed write
//  wr_addr        out  32  word-aligned byte address of the committed write
//  wr_data        out  32  full merged word after the write
//  wr_pc          out  32  m_inst_addr of the committed write
//  err_pulse      out  1   one-cycle flag: write dropped (out of range or not ready)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state<=CLEAR, clr_ptr<=0, and all registered outputs <=0.
//    dm_ready=0. The memory contents are not touched in that cycle.
//  - FSM states: CLEAR and READY.
//    - CLEAR, each cycle: mem[clr_ptr]<=0, clr_ptr<=clr_ptr+1.
//      At clr_ptr==DEPTH_WORDS-1, state<=READY.
//      The clear takes exactly DEPTH_WORDS cycles after reset is released.
//    - READY: stays in READY until reset.
//    - A reset asserted mid-CLEAR restarts the clear from index 0.
//  - in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*DEPTH_WORDS).
//    idx = (addr - BASE_ADDR) >> 2, truncated to IDX_W.
//  - Read: m_data_rdata = (READY && in_range) ? mem[idx] : 32'h0, with zero latency.
//    No error is raised on an out-of-range read, because the address bus also carries
//    ALU results of non-memory instructions.
//  - Write: the write is honoured at a posedge when READY && in_range && byteen!=0.
//    merged[8i+7:8i] = byteen[i] ? wdata[8i+7:8i] : mem[idx][8i+7:8i]; then mem[idx]<=merged.
//    Non-contiguous enables (e.g. 4'b0101) are applied lane by lane and are not rejected.
//  - Read-during-write to the same index: rdata in that cycle shows the OLD word.
//    The new word is visible from the next cycle.
//  - Trace: on an honoured write, in the next cycle wr_valid=1,
//    wr_addr={addr[31:2],2'b00}, wr_data=merged, wr_pc=m_inst_addr.
//    Otherwise wr_valid=0 and the other trace fields hold their last values.
//    Back-to-back writes produce back-to-back strobes.
//  - Dropped write: byteen!=0 while (!in_range || state==CLEAR) causes no array update,
//    wr_valid=0, and err_pulse=1 in the next cycle. err_pulse is 0 otherwise.
//  - Reset has priority over any simultaneous write; that write is lost and not traced.
// STRUCTURE
//  - Shared package/include dm_defs:
//    - DM_DEPTH_WORDS and DM_BASE_ADDR.
//    - Byte-enable constants BE_NONE/BE_WORD/BE_HALF_LO/BE_HALF_HI/BE_B0..BE_B3.
//    - FSM encodings ST_CLEAR and ST_READY.
//    The requester-side extender uses the same BE_* constants.
//  - One sub-module: dm_byte_merge. It is combinational and maps (old_word, wdata, byteen)
//    to merged. The trace path and the array write both reuse it.
//  - The array is a single reg [31:0] mem[0:DEPTH_WORDS-1] with one write port, driven by
//    either the clear pointer or the write path as selected by the state.
// TESTING
//  1. Release reset; count cycles -> dm_ready rises exactly DEPTH_WORDS cycles later.
//     Reading any in-range address before that -> 0.
//  2. After ready: byteen=1111, addr=0x10, wdata=0xDEADBEEF.
//     -> Next cycle rdata@0x10=0xDEADBEEF, wr_valid=1, wr_addr=0x10.
//  3. Then byteen=1100, addr=0x12, wdata=0x12340000 -> word 0x1234BEEF.
//     Then byteen=0010, addr=0x11, wdata=0x0000AA00 -> word 0x1234AAEF, wr_addr=0x10 both times.
//  4. Write to addr=4*DEPTH_WORDS with byteen=0001 -> no array change, wr_valid=0, err_pulse=1.
//     A read at the same address -> rdata=0 with no error.
//  5. Write 0x11111111 to 0x20, then in the next cycle write 0x22222222 to 0x20.
//     During the second cycle rdata=0x11111111; the cycle after, 0x22222222.
//     Two consecutive wr_valid strobes.
//  6. Assert reset mid-CLEAR at clr_ptr≈100, release it.
//     -> clear restarts and takes DEPTH_WORDS cycles; a write issued during CLEAR gives err_pulse=1.

Source files
------------

// File: rtl/dm_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dm_defs (package)
//  Description : Shared definitions for the M-stage data-memory responder:
//                default geometry, byte-enable encodings (also used by the
//                requester-side load/store extender) and FSM state encodings.
//  Revision    : 1.0  initial release
// ============================================================================
package dm_defs;

  localparam int          DM_DEPTH_WORDS = 3072;
  localparam logic [31:0] DM_BASE_ADDR   = 32'h0000_0000;
  localparam int          DM_IDX_W       = 12;

  // Lane enables: bit i covers data bits [8i+7:8i]
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_B0      = 4'b0001;
  localparam logic [3:0] BE_B1      = 4'b0010;
  localparam logic [3:0] BE_B2      = 4'b0100;
  localparam logic [3:0] BE_B3      = 4'b1000;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } dm_state_t;

endpackage : dm_defs
`default_nettype wire

// File: rtl/dm_byte_merge.sv
`default_nettype none
// ============================================================================
//  Module      : dm_byte_merge
//  Description : Combinational lane merge. Each byte lane of the result takes
//                the write data when its enable is set, else the old word.
//  Ports       : old_word [31:0] in  - current array contents
//                wdata    [31:0] in  - lane-aligned write data
//                byteen   [3:0]  in  - per-lane enables
//                merged   [31:0] out - word to be stored / traced
//  Revision    : 1.0  initial release
// ============================================================================
module dm_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] merged
);

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign merged[8*i +: 8] = byteen[i] ? wdata[8*i +: 8] : old_word[8*i +: 8];
  end

endmodule : dm_byte_merge
`default_nettype wire

// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dm_responder
//  Description : Data-memory responder for the M-stage data port. Zero-fills
//                its word array after reset, then serves zero-latency reads
//                and byte-enabled writes, and emits a one-cycle registered
//                write-trace record per committed write.
//  Ports       : clk, reset (sync, active-low)
//                m_data_addr/m_data_wdata/m_data_byteen/m_inst_addr  in
//                m_data_rdata (comb), dm_ready (comb from state)      out
//                wr_valid/wr_addr/wr_data/wr_pc/err_pulse (registered) out
//  Revision    : 1.0  initial release
// ============================================================================
module dm_responder
  import dm_defs::*;
#(
  parameter int          DEPTH_WORDS = DM_DEPTH_WORDS,
  parameter logic [31:0] BASE_ADDR   = DM_BASE_ADDR,
  parameter int          IDX_W       = DM_IDX_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        dm_ready,
  output logic        wr_valid,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] wr_pc,
  output logic        err_pulse
);

  dm_state_t        state;
  dm_state_t        state_next;
  logic [IDX_W-1:0] clr_ptr;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0]      old_word;
  logic [31:0]      merged;
  logic             is_ready;
  logic             has_be;
  logic             wr_ok;
  logic             wr_drop;
  logic             unused_bits;

  // Range test on the offset's word part avoids overflow of BASE+4*DEPTH
  assign offset      = m_data_addr - BASE_ADDR;
  assign in_range    = (m_data_addr >= BASE_ADDR) && (offset[31:2] < 30'(DEPTH_WORDS));
  assign idx         = offset[IDX_W+1:2];
  assign unused_bits = &{1'b0, offset[1:0]};

  assign old_word = mem[idx];
  assign is_ready = (state == ST_READY);
  assign has_be   = |m_data_byteen;
  assign wr_ok    = is_ready && in_range && has_be;
  assign wr_drop  = has_be && !(is_ready && in_range);

  // Out-of-range reads are silent: the bus also carries plain ALU results
  assign m_data_rdata = (is_ready && in_range) ? old_word : 32'h0;

  dm_byte_merge u_merge (
    .old_word (old_word),
    .wdata    (m_data_wdata),
    .byteen   (m_data_byteen),
    .merged   (merged)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    dm_ready   = 1'b0;
    case (state)
      ST_CLEAR: begin
        if (clr_ptr == IDX_W'(DEPTH_WORDS - 1)) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        dm_ready = 1'b1;
      end
      default: begin
        state_next = ST_CLEAR;
      end
    endcase
  end

  // ---------------------------------------------------------------- array
  // Single write port shared between the clear sweep and the data path.
  // Nothing is written in a reset cycle, so reset beats a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == ST_CLEAR) begin
        mem[clr_ptr] <= 32'h0;
      end else if (wr_ok) begin
        mem[idx] <= merged;
      end
    end
  end

  // ---------------------------------------------------------------- pointer / trace
  always_ff @(posedge clk) begin
    if (!reset) begin
      clr_ptr   <= '0;
      wr_valid  <= 1'b0;
      wr_addr   <= 32'h0;
      wr_data   <= 32'h0;
      wr_pc     <= 32'h0;
      err_pulse <= 1'b0;
    end else begin
      if (state == ST_CLEAR) begin
        clr_ptr <= clr_ptr + 1'b1;
      end
      wr_valid  <= wr_ok;
      err_pulse <= wr_drop;
      // Trace fields hold their last values between committed writes
      if (wr_ok) begin
        wr_addr <= {m_data_addr[31:2], 2'b00};
        wr_data <= merged;
        wr_pc   <= m_inst_addr;
      end
    end
  end

endmodule : dm_responder
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_responder
//  Description : Self-checking bench for dm_responder. Expected values are
//                queued with the cycle in which they are due and compared on
//                the falling edge of that cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dm_responder;
  import dm_defs::*;

  localparam int DEPTH = DM_DEPTH_WORDS;

  localparam int SEL_RDATA = 0;
  localparam int SEL_VALID = 1;
  localparam int SEL_ADDR  = 2;
  localparam int SEL_DATA  = 3;
  localparam int SEL_PC    = 4;
  localparam int SEL_ERR   = 5;

  logic        clk;
  logic        reset;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        dm_ready;
  logic        wr_valid;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] wr_pc;
  logic        err_pulse;

  dm_responder dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .dm_ready      (dm_ready),
    .wr_valid      (wr_valid),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_pc         (wr_pc),
    .err_pulse     (err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int          due;
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] model [0:DEPTH-1];
  bit          m_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_RDATA: return m_data_rdata;
      SEL_VALID: return {31'b0, wr_valid};
      SEL_ADDR:  return wr_addr;
      SEL_DATA:  return wr_data;
      SEL_PC:    return wr_pc;
      SEL_ERR:   return {31'b0, err_pulse};
      default:   return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input int due, input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.due = due;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cycle) begin
      exp_t e;
      e = sb.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  // Drive one access for one cycle and queue what the responder must show
  task automatic access(input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] pc);
    longint      off;
    bit          inr;
    int          idx;
    logic [31:0] old;
    logic [31:0] mrg;
    m_data_addr   = addr;
    m_data_byteen = be;
    m_data_wdata  = wd;
    m_inst_addr   = pc;
    off = longint'(addr) - longint'(DM_BASE_ADDR);
    inr = (off >= 0) && (off < longint'(4 * DEPTH));
    idx = inr ? int'(off >>> 2) : 0;
    old = (m_ready && inr) ? model[idx] : 32'h0;
    push(cycle, "rdata", SEL_RDATA, old);
    if (be != 4'b0000 && m_ready && inr) begin
      for (int l = 0; l < 4; l++) mrg[8*l +: 8] = be[l] ? wd[8*l +: 8] : old[8*l +: 8];
      push(cycle + 1, "wr_valid", SEL_VALID, 32'd1);
      push(cycle + 1, "wr_addr",  SEL_ADDR,  {addr[31:2], 2'b00});
      push(cycle + 1, "wr_data",  SEL_DATA,  mrg);
      push(cycle + 1, "wr_pc",    SEL_PC,    pc);
      push(cycle + 1, "err_pulse", SEL_ERR,  32'd0);
      model[idx] = mrg;
    end else begin
      push(cycle + 1, "wr_valid", SEL_VALID, 32'd0);
      push(cycle + 1, "err_pulse", SEL_ERR,  {31'b0, (be != 4'b0000)});
    end
    tick();
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset         = 1'b0;
    m_data_addr   = 32'h0;
    m_data_wdata  = 32'h0;
    m_data_byteen = BE_NONE;
    m_inst_addr   = 32'h0;
    m_ready       = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ready",  {31'b0, dm_ready},  32'd0);
    check("rst_valid",  {31'b0, wr_valid},  32'd0);
    check("rst_err",    {31'b0, err_pulse}, 32'd0);
    check("rst_addr",   wr_addr,  32'h0);
    check("rst_data",   wr_data,  32'h0);
    check("rst_pc",     wr_pc,    32'h0);

    // Clear sweep length and reads during the sweep
    reset       = 1'b1;
    m_data_addr = 32'h10;
    n = 0;
    while (!dm_ready && n < DEPTH + 16) begin
      tick();
      n++;
      if (n == 1) check("rdata_during_clear", m_data_rdata, 32'h0);
    end
    check("clear_cycles", 32'(n), 32'(DEPTH));
    m_ready = 1'b1;
    model_clear();

    // Full-word write then read-back
    access(32'h10, BE_WORD, 32'hDEAD_BEEF, 32'h0000_1000);
    push(cycle, "rdata_deadbeef", SEL_RDATA, 32'hDEAD_BEEF);
    access(32'h10, BE_NONE, 32'h0, 32'h0000_1004);

    // Partial writes into the same word
    access(32'h12, BE_HALF_HI, 32'h1234_0000, 32'h0000_1008);
    push(cycle, "rdata_1234beef", SEL_RDATA, 32'h1234_BEEF);
    access(32'h11, BE_B1, 32'h0000_AA00, 32'h0000_100C);
    push(cycle, "rdata_1234aaef", SEL_RDATA, 32'h1234_AAEF);
    access(32'h10, BE_NONE, 32'h0, 32'h0000_1010);

    // Non-contiguous enables
    access(32'h30, 4'b0101, 32'hAABB_CCDD, 32'h0000_1014);
    push(cycle, "rdata_noncontig", SEL_RDATA, 32'h00BB_00DD);
    access(32'h30, BE_NONE, 32'h0, 32'h0000_1018);

    // Last in-range word, then first out-of-range address
    access(32'(4 * DEPTH - 4), BE_WORD, 32'h5A5A_A5A5, 32'h0000_101C);
    push(cycle, "rdata_last_word", SEL_RDATA, 32'h5A5A_A5A5);
    access(32'(4 * DEPTH - 4), BE_NONE, 32'h0, 32'h0000_1020);
    access(32'(4 * DEPTH), BE_B0, 32'h0000_00FF, 32'h0000_1024);
    push(cycle, "rdata_oor", SEL_RDATA, 32'h0);
    access(32'(4 * DEPTH), BE_NONE, 32'h0, 32'h0000_1028);
    access(32'h0, BE_NONE, 32'h0, 32'h0000_102C);

    // Back-to-back writes to one word: old word visible during the second
    access(32'h20, BE_WORD, 32'h1111_1111, 32'h0000_1030);
    push(cycle, "rdata_rdw_old", SEL_RDATA, 32'h1111_1111);
    access(32'h20, BE_WORD, 32'h2222_2222, 32'h0000_1034);
    push(cycle, "rdata_rdw_new", SEL_RDATA, 32'h2222_2222);
    access(32'h20, BE_NONE, 32'h0, 32'h0000_1038);

    // Reset mid-clear restarts the sweep from index 0
    reset = 1'b0;
    m_ready = 1'b0;
    tick();
    reset = 1'b1;
    repeat (100) tick();
    check("mid_clear_not_ready", {31'b0, dm_ready}, 32'd0);
    reset = 1'b0;
    tick();
    check("rst2_addr",  wr_addr, 32'h0);
    check("rst2_valid", {31'b0, wr_valid}, 32'd0);
    reset = 1'b1;
    access(32'h10, BE_WORD, 32'hCAFE_F00D, 32'h0000_2000);
    m_data_byteen = BE_NONE;
    n = 1;
    while (!dm_ready && n < DEPTH + 16) begin
      tick();
      n++;
    end
    check("reclear_cycles", 32'(n), 32'(DEPTH));
    m_ready = 1'b1;
    model_clear();
    push(cycle, "rdata_after_reclear", SEL_RDATA, 32'h0);
    access(32'h10, BE_NONE, 32'h0, 32'h0000_2004);

    repeat (2) tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_dm_responder
`default_nettype wire
